joycon_poller: RTL and testbench

JOYCON_POLLER -- requirements
Module: joycon_poller

---
 rtl/joycon_pkg.sv | 17 +
 rtl/sync_2ff.sv | 22 ++
 rtl/joycon_poller.sv | 150 +++++++++++++++
 tb/tb_joycon_poller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joycon_pkg.sv
// Shared types and defaults for the NES-style joypad poller.
// Holds the FSM state encoding, the default half period and the counter width.
package joycon_pkg;

  localparam int HALF_CYC_DEF = 150;
  localparam int CNT_W        = 11;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT0,
    CLK_LO,
    CLK_HI,
    DONE
  } joy_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous serial data line.
// Ports: clk, rst (async active-low, resets to 1), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joycon_poller.sv
// Polls two NES-style joypads over a shared latch/clock on each poll_req edge.
// Ports: clk, rst (async low), poll_req, joy_data1/2 in; joy_latch, joy_clk,
// joycon_1/2 (1 = pressed), joy_valid (commit pulse), busy out.
module joycon_poller
  import joycon_pkg::*;
#(
  parameter int HALF_CYC = HALF_CYC_DEF,
  parameter bit DEBOUNCE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       joy_data1,
  input  logic       joy_data2,
  output logic       joy_latch,
  output logic       joy_clk,
  output logic [7:0] joycon_1,
  output logic [7:0] joycon_2,
  output logic       joy_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HC_END = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] LT_END = CNT_W'(2 * HALF_CYC - 1);

  joy_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic             poll_q, poll_edge;
  logic             d1, d2;
  logic             sample, commit;
  logic [7:0]       shf1, shf2;
  logic [7:0]       raw1, raw2;

  sync_2ff u_sync1 (
    .clk (clk),
    .rst (rst),
    .d   (joy_data1),
    .q   (d1)
  );

  sync_2ff u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (joy_data2),
    .q   (d2)
  );

  assign poll_edge = poll_req & ~poll_q;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    sample  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (poll_edge) state_n = LATCH;
      end
      LATCH: begin
        if (cnt == LT_END) begin
          state_n = WAIT0;
          cnt_n   = '0;
        end
      end
      WAIT0: begin
        if (cnt == HC_END) begin
          state_n = CLK_LO;
          cnt_n   = '0;
          sample  = 1'b1;
          idx_n   = 3'd1;
        end
      end
      CLK_LO: begin
        if (cnt == HC_END) begin
          state_n = CLK_HI;
          cnt_n   = '0;
        end
      end
      CLK_HI: begin
        if (cnt == HC_END) begin
          cnt_n  = '0;
          sample = 1'b1;
          if (idx == 3'd7) begin
            state_n = DONE;
          end else begin
            state_n = CLK_LO;
            idx_n   = idx + 3'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Debounce compares the fresh frame with the previous raw frame.
  assign commit = (state == DONE) &&
                  (!DEBOUNCE ||
                   ((shf1 == raw1) && (shf2 == raw2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      poll_q    <= 1'b0;
      joy_latch <= 1'b0;
      joy_clk   <= 1'b1;
      joy_valid <= 1'b0;
      shf1      <= '0;
      shf2      <= '0;
      raw1      <= '0;
      raw2      <= '0;
      joycon_1  <= '0;
      joycon_2  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      poll_q    <= poll_req;
      // Pin levels follow the next state so they align with it.
      joy_latch <= (state_n == LATCH);
      joy_clk   <= (state_n != CLK_LO);
      joy_valid <= commit;
      if (sample) begin
        shf1[idx] <= ~d1;
        shf2[idx] <= ~d2;
      end
      if (state == DONE) begin
        raw1 <= shf1;
        raw2 <= shf2;
      end
      if (commit) begin
        joycon_1 <= shf1;
        joycon_2 <= shf2;
      end
    end
  end

endmodule

// File: tb/tb_joycon_poller.sv
// Bench for joycon_poller: two instances (DEBOUNCE 0 and 1), HALF_CYC 4,
// each driven by a shift-register joypad model; frame-level reference model.
module tb_joycon_poller;

  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic       poll  [2];
  logic       jd1   [2];
  logic       jd2   [2];
  logic       jl    [2];
  logic       jc    [2];
  logic [7:0] j1    [2];
  logic [7:0] j2    [2];
  logic       val   [2];
  logic       bsy   [2];
  logic [7:0] btn1  [2];
  logic [7:0] btn2  [2];
  logic       disc  [2];

  int nval  [2] = '{0, 0};
  int nlat  [2] = '{0, 0};
  int nbusy [2] = '{0, 0};
  int nlow  [2] = '{0, 0};
  int nfall [2] = '{0, 0};
  int nbad  [2] = '{0, 0};
  logic       pjc [2] = '{1'b1, 1'b1};
  logic [7:0] pj1 [2] = '{8'h00, 8'h00};
  logic [7:0] pj2 [2] = '{8'h00, 8'h00};

  logic [7:0] prev1 [2];
  logic [7:0] prev2 [2];
  logic [7:0] exp1  [2];
  logic [7:0] exp2  [2];

  int ncmp = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [7:0] s1, s2;

    joycon_poller #(
      .HALF_CYC (H),
      .DEBOUNCE (g == 1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .poll_req  (poll[g]),
      .joy_data1 (jd1[g]),
      .joy_data2 (jd2[g]),
      .joy_latch (jl[g]),
      .joy_clk   (jc[g]),
      .joycon_1  (j1[g]),
      .joycon_2  (j2[g]),
      .joy_valid (val[g]),
      .busy      (bsy[g])
    );

    // 4021-style pad: parallel load on latch, shift on clock rise.
    always @(posedge jl[g] or posedge jc[g]) begin
      if (jl[g]) begin
        s1 <= btn1[g];
        s2 <= btn2[g];
      end else begin
        s1 <= {1'b0, s1[7:1]};
        s2 <= {1'b0, s2[7:1]};
      end
    end

    assign jd1[g] = disc[g] | ~s1[0];
    assign jd2[g] = disc[g] | ~s2[0];
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (val[k]) nval[k] <= nval[k] + 1;
      if (jl[k]) nlat[k] <= nlat[k] + 1;
      if (bsy[k]) nbusy[k] <= nbusy[k] + 1;
      if (!jc[k]) nlow[k] <= nlow[k] + 1;
      if (pjc[k] && !jc[k]) nfall[k] <= nfall[k] + 1;
      if (rst && !val[k] && (j1[k] != pj1[k] || j2[k] != pj2[k]))
        nbad[k] <= nbad[k] + 1;
      pjc[k] <= jc[k];
      pj1[k] <= j1[k];
      pj2[k] <= j2[k];
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      prev1[k] = 8'h00;
      prev2[k] = 8'h00;
      exp1[k]  = 8'h00;
      exp2[k]  = 8'h00;
    end
  endtask

  // Frame-level expectation: pressed buttons, debounced on instance 1.
  task automatic model_poll(input int g, output int com);
    logic [7:0] f1, f2;
    f1  = disc[g] ? 8'h00 : btn1[g];
    f2  = disc[g] ? 8'h00 : btn2[g];
    com = (g == 0 || (f1 == prev1[g] && f2 == prev2[g])) ? 1 : 0;
    prev1[g] = f1;
    prev2[g] = f2;
    if (com == 1) begin
      exp1[g] = f1;
      exp2[g] = f2;
    end
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_j1"}, 32'(j1[k]), 32'h0);
      chk({tag, "_j2"}, 32'(j2[k]), 32'h0);
      chk({tag, "_busy"}, 32'(bsy[k]), 32'h0);
    end
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_poll(input int g, input int second);
    int t;
    @(negedge clk);
    poll[g] = 1'b1;
    repeat (3) @(negedge clk);
    poll[g] = 1'b0;
    if (second != 0) begin
      repeat (15) @(negedge clk);
      poll[g] = 1'b1;
      repeat (3) @(negedge clk);
      poll[g] = 1'b0;
    end
    t = 0;
    while (bsy[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("poll_timeout", 32'(t < 200), 32'h1);
    repeat (3) @(negedge clk);
  endtask

  task automatic poll_check(string tag, input int g, input int second);
    int v0, l0, b0, w0, f0, com;
    v0 = nval[g];
    l0 = nlat[g];
    b0 = nbusy[g];
    w0 = nlow[g];
    f0 = nfall[g];
    run_poll(g, second);
    model_poll(g, com);
    chk({tag, "_valid"}, 32'(nval[g] - v0), 32'(com));
    chk({tag, "_j1"}, 32'(j1[g]), 32'(exp1[g]));
    chk({tag, "_j2"}, 32'(j2[g]), 32'(exp2[g]));
    chk({tag, "_latch"}, 32'(nlat[g] - l0), 32'(2 * H));
    chk({tag, "_busy"}, 32'(nbusy[g] - b0), 32'(17 * H + 1));
    chk({tag, "_clklow"}, 32'(nlow[g] - w0), 32'(7 * H));
    chk({tag, "_falls"}, 32'(nfall[g] - f0), 32'h7);
  endtask

  initial begin
    int t, v0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      poll[k] = 1'b0;
      btn1[k] = 8'h00;
      btn2[k] = 8'h00;
      disc[k] = 1'b0;
    end
    model_clear();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_latch", 32'(jl[k]), 32'h0);
      chk("rst_clk", 32'(jc[k]), 32'h1);
      chk("rst_valid", 32'(val[k]), 32'h0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // A+Start on pad 1, Right on pad 2, no debounce.
    btn1[0] = 8'h09;
    btn2[0] = 8'h80;
    poll_check("s1", 0, 0);
    chk("s1_j1_const", 32'(j1[0]), 32'h09);
    chk("s1_j2_const", 32'(j2[0]), 32'h80);

    for (int i = 0; i < 4; i++) begin
      btn1[0] = 8'($urandom);
      btn2[0] = 8'($urandom);
      disc[0] = ($urandom_range(0, 3) == 0);
      poll_check("rnd0", 0, 0);
    end
    disc[0] = 1'b0;

    // Second edge during busy must be dropped.
    btn1[0] = 8'h5A;
    btn2[0] = 8'hC3;
    poll_check("s4", 0, 1);

    // Reset inside CLK_HI of bit 3.
    btn1[0] = 8'hFF;
    btn2[0] = 8'h3C;
    v0 = nval[0];
    @(negedge clk);
    poll[0] = 1'b1;
    t = 0;
    while (!jl[0] && t < 10) begin
      @(negedge clk);
      t++;
    end
    poll[0] = 1'b0;
    chk("s5_start", 32'(jl[0]), 32'h1);
    repeat (34) @(posedge clk);
    #1;
    chk("s5_clkhi", 32'(jc[0]), 32'h1);
    chk("s5_busy_pre", 32'(bsy[0]), 32'h1);
    rst = 1'b0;
    #1;
    chk("s5_j1", 32'(j1[0]), 32'h0);
    chk("s5_j2", 32'(j2[0]), 32'h0);
    chk("s5_latch", 32'(jl[0]), 32'h0);
    chk("s5_clk", 32'(jc[0]), 32'h1);
    chk("s5_busy", 32'(bsy[0]), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (20) @(negedge clk);
    chk("s5_idle", 32'(bsy[0]), 32'h0);
    chk("s5_novalid", 32'(nval[0] - v0), 32'h0);

    // Disconnected pads read as nothing pressed.
    btn1[0] = 8'hA5;
    btn2[0] = 8'h3C;
    poll_check("s6_pre", 0, 0);
    disc[0] = 1'b1;
    poll_check("s6", 0, 0);
    chk("s6_j1_const", 32'(j1[0]), 32'h00);
    disc[0] = 1'b0;

    // Debounce: same frame twice.
    btn1[1] = 8'h01;
    btn2[1] = 8'h00;
    poll_check("s2a", 1, 0);
    chk("s2a_const", 32'(j1[1]), 32'h00);
    poll_check("s2b", 1, 0);
    chk("s2b_const", 32'(j1[1]), 32'h01);

    // Debounce: 01, 02, 02.
    do_reset("s3rst");
    btn1[1] = 8'h01;
    poll_check("s3a", 1, 0);
    btn1[1] = 8'h02;
    poll_check("s3b", 1, 0);
    chk("s3b_const", 32'(j1[1]), 32'h00);
    poll_check("s3c", 1, 0);
    chk("s3c_const", 32'(j1[1]), 32'h02);

    for (int i = 0; i < 3; i++) begin
      btn1[1] = 8'($urandom);
      btn2[1] = 8'($urandom);
      disc[1] = ($urandom_range(0, 3) == 0);
      poll_check("rnd1a", 1, 0);
      poll_check("rnd1b", 1, 0);
    end
    disc[1] = 1'b1;
    poll_check("s6b_a", 1, 0);
    poll_check("s6b_b", 1, 0);

    chk("outs_only_on_valid0", 32'(nbad[0]), 32'h0);
    chk("outs_only_on_valid1", 32'(nbad[1]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
